// File: rtl/xif_issue_recorder_if.sv
// CV-X-IF issue channel: core request (valid/instr/id), recorder ready, and the
// same-cycle accept/writeback response.
interface xif_issue_recorder_if #(
  parameter int unsigned X_ID_WIDTH = 4
);
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [31:0]           issue_instr_i;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic                  issue_accept_o;
  logic                  issue_writeback_o;

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o
  );

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o
  );
endinterface

// File: rtl/xif_issue_recorder.sv
// Stand-in coprocessor on the CV-X-IF issue channel: decides accept by opcode match,
// records every transfer into a fall-through FIFO and keeps saturating statistics.
module xif_issue_recorder #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned DEPTH       = 8,
  parameter bit          LOSSLESS    = 1'b1,
  parameter logic [31:0] MATCH_MASK  = 32'h0000_007F,
  parameter logic [31:0] MATCH_VALUE = 32'h0000_000B,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter bit          VERBOSE     = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  xif_issue_recorder_if.slave    issue_if,
  output logic                   rec_valid_o,
  input  logic                   rec_ready_i,
  output logic [31:0]            rec_instr_o,
  output logic [X_ID_WIDTH-1:0]  rec_id_o,
  output logic                   rec_accept_o,
  output logic [$clog2(DEPTH):0] level_o,
  input  logic                   clr_cnt_i,
  output logic [CNT_WIDTH-1:0]   cnt_issue_o,
  output logic [CNT_WIDTH-1:0]   cnt_accept_o,
  output logic [CNT_WIDTH-1:0]   cnt_drop_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]           instr;
    logic [X_ID_WIDTH-1:0] id;
    logic                  accept;
  } rec_t;

  rec_t                 r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_ready;
  logic [CNT_WIDTH-1:0] r_cnt_issue;
  logic [CNT_WIDTH-1:0] r_cnt_accept;
  logic [CNT_WIDTH-1:0] r_cnt_drop;

  logic             w_accept;
  logic             w_writeback;
  logic             w_full;
  logic             w_xfer;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [LVL_W-1:0] w_level_nxt;
  rec_t             w_rec;

  // Decode is the only combinational path through the block.
  assign w_accept    = (issue_if.issue_instr_i & MATCH_MASK) == MATCH_VALUE;
  assign w_writeback = w_accept & (|issue_if.issue_instr_i[11:7]);

  assign issue_if.issue_accept_o    = w_accept;
  assign issue_if.issue_writeback_o = w_writeback;
  assign issue_if.issue_ready_o     = r_ready;

  assign w_full = (r_level == LVL_W'(DEPTH));
  assign w_xfer = issue_if.issue_valid_i & r_ready;
  assign w_pop  = (r_level != '0) & rec_ready_i;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign w_push = w_xfer & (~w_full | w_pop);
  assign w_drop = w_xfer & w_full & ~w_pop;

  assign w_rec.instr  = issue_if.issue_instr_i;
  assign w_rec.id     = issue_if.issue_id_i;
  assign w_rec.accept = w_accept;

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage, pointers, occupancy and the registered ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_rec;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_ready <= LOSSLESS ? (w_level_nxt != LVL_W'(DEPTH)) : 1'b1;
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 inc);
    return (inc && (cnt != '1)) ? cnt + CNT_WIDTH'(1) : cnt;
  endfunction

  // Clear takes priority over any same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt_issue  <= '0;
      r_cnt_accept <= '0;
      r_cnt_drop   <= '0;
    end else if (clr_cnt_i) begin
      r_cnt_issue  <= '0;
      r_cnt_accept <= '0;
      r_cnt_drop   <= '0;
    end else begin
      r_cnt_issue  <= sat_inc(r_cnt_issue, w_xfer);
      r_cnt_accept <= sat_inc(r_cnt_accept, w_xfer & w_accept);
      r_cnt_drop   <= sat_inc(r_cnt_drop, w_drop);
    end
  end

  assign rec_valid_o  = (r_level != '0);
  assign rec_instr_o  = r_mem[r_rptr].instr;
  assign rec_id_o     = r_mem[r_rptr].id;
  assign rec_accept_o = r_mem[r_rptr].accept;
  assign level_o      = r_level;
  assign cnt_issue_o  = r_cnt_issue;
  assign cnt_accept_o = r_cnt_accept;
  assign cnt_drop_o   = r_cnt_drop;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (VERBOSE && !rst_i && w_xfer)
      $display("[xif_issue_recorder] t=%0t id=%0h instr=%08h accept=%0b",
               $time, issue_if.issue_id_i, issue_if.issue_instr_i, w_accept);
  end
`endif

endmodule

// File: tb/tb_xif_issue_recorder.sv
// Bench for xif_issue_recorder: three configurations (lossless, lossy, 4-bit counters)
// share one stimulus stream and are checked against a queue-based reference model.
module tb_xif_issue_recorder;
  localparam int unsigned IDW = 4;
  localparam int NI = 3;

  typedef struct packed {
    logic [31:0]    instr;
    logic [IDW-1:0] id;
    logic           acc;
  } rec_t;

  logic           clk;
  logic           rst;
  logic           valid;
  logic [31:0]    instr;
  logic [IDW-1:0] id;
  logic           rr;
  logic           clr;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xif_issue_recorder_if #(.X_ID_WIDTH(IDW)) if_a ();
  xif_issue_recorder_if #(.X_ID_WIDTH(IDW)) if_b ();
  xif_issue_recorder_if #(.X_ID_WIDTH(IDW)) if_c ();

  assign if_a.issue_valid_i = valid;
  assign if_a.issue_instr_i = instr;
  assign if_a.issue_id_i    = id;
  assign if_b.issue_valid_i = valid;
  assign if_b.issue_instr_i = instr;
  assign if_b.issue_id_i    = id;
  assign if_c.issue_valid_i = valid;
  assign if_c.issue_instr_i = instr;
  assign if_c.issue_id_i    = id;

  logic           rv_a, ra_a, rv_b, ra_b, rv_c, ra_c;
  logic [31:0]    ri_a, ri_b, ri_c;
  logic [IDW-1:0] rid_a, rid_b, rid_c;
  logic [3:0]     lv_a, lv_b, lv_c;
  logic [15:0]    ci_a, ca_a, cd_a, ci_b, ca_b, cd_b;
  logic [3:0]     ci_c, ca_c, cd_c;

  xif_issue_recorder #(.X_ID_WIDTH(IDW), .DEPTH(8), .LOSSLESS(1'b1), .CNT_WIDTH(16)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .issue_if(if_a.slave),
    .rec_valid_o(rv_a), .rec_ready_i(rr), .rec_instr_o(ri_a), .rec_id_o(rid_a),
    .rec_accept_o(ra_a), .level_o(lv_a), .clr_cnt_i(clr),
    .cnt_issue_o(ci_a), .cnt_accept_o(ca_a), .cnt_drop_o(cd_a)
  );

  xif_issue_recorder #(.X_ID_WIDTH(IDW), .DEPTH(8), .LOSSLESS(1'b0), .CNT_WIDTH(16)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .issue_if(if_b.slave),
    .rec_valid_o(rv_b), .rec_ready_i(rr), .rec_instr_o(ri_b), .rec_id_o(rid_b),
    .rec_accept_o(ra_b), .level_o(lv_b), .clr_cnt_i(clr),
    .cnt_issue_o(ci_b), .cnt_accept_o(ca_b), .cnt_drop_o(cd_b)
  );

  xif_issue_recorder #(.X_ID_WIDTH(IDW), .DEPTH(8), .LOSSLESS(1'b1), .CNT_WIDTH(4)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .issue_if(if_c.slave),
    .rec_valid_o(rv_c), .rec_ready_i(rr), .rec_instr_o(ri_c), .rec_id_o(rid_c),
    .rec_accept_o(ra_c), .level_o(lv_c), .clr_cnt_i(clr),
    .cnt_issue_o(ci_c), .cnt_accept_o(ca_c), .cnt_drop_o(cd_c)
  );

  logic           o_ready [NI];
  logic           o_acc   [NI];
  logic           o_wb    [NI];
  logic           o_rv    [NI];
  logic           o_racc  [NI];
  logic [31:0]    o_ri    [NI];
  logic [IDW-1:0] o_rid   [NI];
  logic [3:0]     o_lv    [NI];
  logic [15:0]    o_ci    [NI];
  logic [15:0]    o_ca    [NI];
  logic [15:0]    o_cd    [NI];

  always_comb begin
    o_ready[0] = if_a.issue_ready_o; o_acc[0] = if_a.issue_accept_o; o_wb[0] = if_a.issue_writeback_o;
    o_ready[1] = if_b.issue_ready_o; o_acc[1] = if_b.issue_accept_o; o_wb[1] = if_b.issue_writeback_o;
    o_ready[2] = if_c.issue_ready_o; o_acc[2] = if_c.issue_accept_o; o_wb[2] = if_c.issue_writeback_o;
    o_rv[0] = rv_a;  o_rv[1] = rv_b;  o_rv[2] = rv_c;
    o_racc[0] = ra_a; o_racc[1] = ra_b; o_racc[2] = ra_c;
    o_ri[0] = ri_a;  o_ri[1] = ri_b;  o_ri[2] = ri_c;
    o_rid[0] = rid_a; o_rid[1] = rid_b; o_rid[2] = rid_c;
    o_lv[0] = lv_a;  o_lv[1] = lv_b;  o_lv[2] = lv_c;
    o_ci[0] = ci_a;  o_ci[1] = ci_b;  o_ci[2] = {12'd0, ci_c};
    o_ca[0] = ca_a;  o_ca[1] = ca_b;  o_ca[2] = {12'd0, ca_c};
    o_cd[0] = cd_a;  o_cd[1] = cd_b;  o_cd[2] = {12'd0, cd_c};
  end

  // Reference model: an ordered list of records plus plain integer counters.
  rec_t mq [NI][$];
  int   m_ci [NI];
  int   m_ca [NI];
  int   m_cd [NI];

  function automatic bit is_lossless(input int k);
    return k != 1;
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic bit exp_accept(input logic [31:0] ins);
    return (ins & 32'h0000_007F) == 32'h0000_000B;
  endfunction

  function automatic int sat(input int v, input int k);
    return (v > cnt_max(k)) ? cnt_max(k) : v;
  endfunction

  function automatic void chk(input string tag, input int k, input logic [63:0] obs,
                              input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endfunction

  function automatic void check_all(input logic v);
    for (int k = 0; k < NI; k++) begin
      int sz;
      sz = mq[k].size();
      chk("issue_ready", k, 64'(o_ready[k]), 64'(!(is_lossless(k) && sz >= 8)));
      if (v) begin
        chk("accept", k, 64'(o_acc[k]), 64'(exp_accept(instr)));
        chk("writeback", k, 64'(o_wb[k]), 64'(exp_accept(instr) && (instr[11:7] != 5'd0)));
      end
      chk("level", k, 64'(o_lv[k]), 64'(sz));
      chk("rec_valid", k, 64'(o_rv[k]), 64'(sz != 0));
      if (sz != 0) begin
        chk("rec_instr", k, 64'(o_ri[k]), 64'(mq[k][0].instr));
        chk("rec_id", k, 64'(o_rid[k]), 64'(mq[k][0].id));
        chk("rec_accept", k, 64'(o_racc[k]), 64'(mq[k][0].acc));
      end
      chk("cnt_issue", k, 64'(o_ci[k]), 64'(m_ci[k]));
      chk("cnt_accept", k, 64'(o_ca[k]), 64'(m_ca[k]));
      chk("cnt_drop", k, 64'(o_cd[k]), 64'(m_cd[k]));
    end
  endfunction

  function automatic void model_edge(input logic v, input logic [31:0] ins,
                                     input logic [IDW-1:0] idv, input logic r, input logic c);
    for (int k = 0; k < NI; k++) begin
      bit   rdy, xfer, a, dropped;
      rec_t rc;
      rdy     = !(is_lossless(k) && mq[k].size() >= 8);
      xfer    = v && rdy;
      a       = exp_accept(ins);
      dropped = 1'b0;
      if (r && mq[k].size() != 0) void'(mq[k].pop_front());
      if (xfer) begin
        rc.instr = ins; rc.id = idv; rc.acc = a;
        if (mq[k].size() < 8) mq[k].push_back(rc);
        else dropped = 1'b1;
      end
      if (c) begin
        m_ci[k] = 0; m_ca[k] = 0; m_cd[k] = 0;
      end else begin
        if (xfer)      m_ci[k] = sat(m_ci[k] + 1, k);
        if (xfer && a) m_ca[k] = sat(m_ca[k] + 1, k);
        if (dropped)   m_cd[k] = sat(m_cd[k] + 1, k);
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      m_ci[k] = 0; m_ca[k] = 0; m_cd[k] = 0;
    end
  endfunction

  // Called at posedge+1: drive, check mid-cycle, advance one edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [IDW-1:0] idv,
                      input logic r, input logic c);
    valid = v; instr = ins; id = idv; rr = r; clr = c;
    #4;
    check_all(v);
    @(posedge clk);
    model_edge(v, ins, idv, r, c);
    #1;
  endtask

  function automatic void check_reset_state(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_level"}, k, 64'(o_lv[k]), 64'd0);
      chk({tag, "_rec_valid"}, k, 64'(o_rv[k]), 64'd0);
      chk({tag, "_rec_instr"}, k, 64'(o_ri[k]), 64'd0);
      chk({tag, "_rec_id"}, k, 64'(o_rid[k]), 64'd0);
      chk({tag, "_rec_accept"}, k, 64'(o_racc[k]), 64'd0);
      chk({tag, "_cnt_issue"}, k, 64'(o_ci[k]), 64'd0);
      chk({tag, "_cnt_accept"}, k, 64'(o_ca[k]), 64'd0);
      chk({tag, "_cnt_drop"}, k, 64'(o_cd[k]), 64'd0);
      chk({tag, "_ready"}, k, 64'(o_ready[k]), 64'd1);
    end
  endfunction

  initial begin
    logic [31:0]    r_ins;
    logic           r_v, r_r, r_c;

    rst = 1'b1; valid = 1'b0; instr = '0; id = '0; rr = 1'b0; clr = 1'b0;
    model_reset();
    #2;
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // First accepted instruction with rd=1.
    step(1'b1, 32'h0000_008B, 4'd3, 1'b0, 1'b0);
    chk("first_rec_instr", 0, 64'(o_ri[0]), 64'h8B);
    chk("first_rec_id", 0, 64'(o_rid[0]), 64'd3);
    chk("first_cnt_issue", 0, 64'(o_ci[0]), 64'd1);
    chk("first_cnt_accept", 0, 64'(o_ca[0]), 64'd1);

    // OP opcode is rejected but still recorded; custom-0 with rd=0 accepts without writeback.
    step(1'b1, 32'h0000_0033, 4'd4, 1'b0, 1'b0);
    step(1'b1, 32'h0000_000B, 4'd5, 1'b0, 1'b0);
    chk("three_cnt_issue", 0, 64'(o_ci[0]), 64'd3);
    chk("three_cnt_accept", 0, 64'(o_ca[0]), 64'd2);
    step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
    chk("rejected_rec_instr", 0, 64'(o_ri[0]), 64'h33);
    chk("rejected_rec_accept", 0, 64'(o_racc[0]), 64'd0);
    step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);

    // Fill with no consumer.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h0000_008B, IDW'(i), 1'b0, 1'b0);
    chk("fill_level", 0, 64'(o_lv[0]), 64'd8);
    chk("fill_ready", 0, 64'(o_ready[0]), 64'd0);
    chk("lossy_level", 1, 64'(o_lv[1]), 64'd8);
    chk("lossy_drop", 1, 64'(o_cd[1]), 64'd2);
    chk("lossy_ready", 1, 64'(o_ready[1]), 64'd1);
    step(1'b1, 32'h0000_008B, 4'd10, 1'b0, 1'b0);
    chk("lossy_drop3", 1, 64'(o_cd[1]), 64'd3);
    step(1'b1, 32'h0000_008B, 4'd11, 1'b1, 1'b0);
    chk("ready_back", 0, 64'(o_ready[0]), 64'd1);
    chk("pop_level", 0, 64'(o_lv[0]), 64'd7);
    chk("lossy_pushpop_drop", 1, 64'(o_cd[1]), 64'd3);
    chk("lossy_pushpop_level", 1, 64'(o_lv[1]), 64'd8);
    step(1'b1, 32'h0000_008B, 4'd8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 0, 64'(o_rid[0]), 64'(i + 1));
      step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
    end
    step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);

    // Saturation with continuous drain, then clear against a same-cycle transfer.
    for (int i = 0; i < 20; i++) step(1'b1, 32'h0000_010B, IDW'(i), 1'b1, 1'b0);
    chk("sat_cnt_issue", 2, 64'(o_ci[2]), 64'd15);
    chk("sat_cnt_accept", 2, 64'(o_ca[2]), 64'd15);
    step(1'b1, 32'h0000_000B, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < NI; k++) begin
      chk("clr_cnt_issue", k, 64'(o_ci[k]), 64'd0);
      chk("clr_cnt_accept", k, 64'(o_ca[k]), 64'd0);
      chk("clr_cnt_drop", k, 64'(o_cd[k]), 64'd0);
    end
    step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);

    // Random traffic, alternating phases of slow and fast draining.
    for (int i = 0; i < 400; i++) begin
      r_v   = ($urandom_range(0, 3) != 0);
      r_ins = $urandom;
      if ($urandom_range(0, 1) == 1) r_ins[6:0] = 7'h0B;
      r_r   = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r_c   = ($urandom_range(0, 31) == 0);
      step(r_v, r_ins, IDW'($urandom), r_r, r_c);
    end
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);

    // Asynchronous reset with five records queued.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_008B, IDW'(i), 1'b0, 1'b0);
    chk("pre_reset_level", 0, 64'(o_lv[0]), 64'd5);
    valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 32'h1234_508B, 4'd9, 1'b0, 1'b0);
    chk("post_reset_instr", 0, 64'(o_ri[0]), 64'h1234_508B);
    chk("post_reset_id", 0, 64'(o_rid[0]), 64'd9);
    chk("post_reset_level", 0, 64'(o_lv[0]), 64'd1);
    step(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
